// File: rtl/sm_pkg.sv
// Shared types for the sign-magnitude add/subtract pipeline.
// Holds the operation enum, the S1 bundle and the magnitude-max helper.
package sm_pkg;

    // Magnitude storage width in the S1 bundle; supports W up to 32.
    localparam int SM_MW = 32;

    typedef enum logic {
        SM_ADD = 1'b0,
        SM_SUB = 1'b1
    } sm_op_e;

    // Magnitudes are zero-extended to SM_MW; only [W-2:0] carry data.
    typedef struct packed {
        logic             sa;
        logic             sb;
        logic [SM_MW-1:0] ma;
        logic [SM_MW-1:0] mb;
        logic             eff_sub;
        logic             swap;
    } sm_s1_t;

    // All-ones magnitude for a W-bit sign-magnitude field.
    function automatic logic [SM_MW-1:0] sm_mag_max(input int w);
        return SM_MW'((64'd1 << (w - 1)) - 64'd1);
    endfunction

endpackage

// File: rtl/sm_addsub_pipe_if.sv
// Valid/ready operand and result bus of the sign-magnitude add/sub unit.
// master: producer/consumer side; slave: the arithmetic unit.
interface sm_addsub_pipe_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] c;
    logic         cout;
    logic         zero;
    logic         overflow;
    logic         neg;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, c, cout, zero, overflow, neg
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, c, cout, zero, overflow, neg
    );

endinterface

// File: rtl/sm_mag_core.sv
// Combinational magnitude add/subtract between S1 and S2.
// Ports: eff_sub_i, swap_i, ma_i, mb_i in; mag_o (W-1 bits), cout_o out.
module sm_mag_core
    import sm_pkg::*;
#(
    parameter int W = 16
) (
    input  logic             eff_sub_i,
    input  logic             swap_i,
    input  logic [SM_MW-1:0] ma_i,
    input  logic [SM_MW-1:0] mb_i,
    output logic [W-2:0]     mag_o,
    output logic             cout_o
);

    logic [W-2:0] xa;
    logic [W-2:0] xb;
    logic         unused_hi;

    assign xa = ma_i[W-2:0];
    assign xb = mb_i[W-2:0];

    // Upper bits of the bundle magnitudes are always zero.
    assign unused_hi = ^{ma_i[SM_MW-1:W-1], mb_i[SM_MW-1:W-1]};

    // Subtract larger minus smaller so the magnitude never goes negative.
    always_comb begin
        mag_o  = '0;
        cout_o = 1'b0;
        if (eff_sub_i) begin
            mag_o = swap_i ? (xb - xa) : (xa - xb);
        end else begin
            {cout_o, mag_o} = {1'b0, xa} + {1'b0, xb};
        end
    end

endmodule

// File: rtl/sm_addsub_pipe.sv
// Two-stage pipelined sign-magnitude add/subtract with valid/ready flow.
// Ports: clk_i, rst_i (sync, high), clr_sticky_i, sticky_ovf_o, bus (slave).
module sm_addsub_pipe
    import sm_pkg::*;
#(
    parameter int N   = 32,
    parameter int W   = 16,
    parameter bit SAT = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_sticky_i,
    output logic            sticky_ovf_o,
    sm_addsub_pipe_if.slave bus
);

    localparam logic [SM_MW-1:0] MagMax = sm_mag_max(W);

    logic         en1;
    logic         en2;
    sm_s1_t       s1_d;
    sm_s1_t       s1_q;
    logic         s1_valid_q;
    logic         s2_valid_q;
    logic [W-2:0] core_mag;
    logic         core_cout;
    logic [W-2:0] mag_d;
    logic         sign_raw;
    logic         sign_d;
    logic         ovf_d;
    logic [N-1:0] c_d;
    logic [N-1:0] c_q;
    logic         cout_q;
    logic         zero_q;
    logic         ovf_q;
    logic         neg_q;
    logic         sticky_q;

    // A stage may load when empty or when its content moves on.
    assign en2          = !s2_valid_q || bus.out_ready;
    assign en1          = !s1_valid_q || en2;
    assign bus.in_ready = en1;

    generate
        if (W < N) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^{bus.a[N-1:W], bus.b[N-1:W]};
        end
    endgenerate

    always_comb begin
        s1_d         = '0;
        s1_d.sa      = bus.a[W-1];
        s1_d.sb      = bus.b[W-1] ^ bus.sub;
        s1_d.ma      = SM_MW'(bus.a[W-2:0]);
        s1_d.mb      = SM_MW'(bus.b[W-2:0]);
        s1_d.eff_sub = s1_d.sa ^ s1_d.sb;
        s1_d.swap    = s1_d.mb > s1_d.ma;
    end

    sm_mag_core #(
        .W(W)
    ) u_core (
        .eff_sub_i(s1_q.eff_sub),
        .swap_i   (s1_q.swap),
        .ma_i     (s1_q.ma),
        .mb_i     (s1_q.mb),
        .mag_o    (core_mag),
        .cout_o   (core_cout)
    );

    // A zero magnitude always carries a positive sign.
    always_comb begin
        ovf_d    = !s1_q.eff_sub && core_cout;
        mag_d    = (SAT && ovf_d) ? MagMax[W-2:0] : core_mag;
        sign_raw = (s1_q.eff_sub && s1_q.swap) ? s1_q.sb : s1_q.sa;
        sign_d   = (mag_d != '0) && sign_raw;
        c_d      = '0;
        c_d[W-1:0] = {sign_d, mag_d};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else if (en1) begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_valid_q <= 1'b0;
            c_q        <= '0;
            cout_q     <= 1'b0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            neg_q      <= 1'b0;
        end else if (en2) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                c_q    <= c_d;
                cout_q <= core_cout;
                zero_q <= (mag_d == '0);
                ovf_q  <= ovf_d;
                neg_q  <= sign_d;
            end
        end
    end

    // Setting on a delivered overflow beats a same-cycle clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sticky_q <= 1'b0;
        end else if (s2_valid_q && bus.out_ready && ovf_q) begin
            sticky_q <= 1'b1;
        end else if (clr_sticky_i) begin
            sticky_q <= 1'b0;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.c         = c_q;
    assign bus.cout      = cout_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
    assign bus.neg       = neg_q;
    assign sticky_ovf_o  = sticky_q;

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Directed bench for sm_addsub_pipe: SAT=1 and SAT=0 units fed alike.
// Flags are packed as {cout, zero, overflow, neg}.
module tb_sm_addsub_pipe;
    import sm_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic clr;
    logic sticky1;
    logic sticky0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    sm_addsub_pipe_if #(.N(32)) bus1 ();
    sm_addsub_pipe_if #(.N(32)) bus0 ();

    assign bus0.in_valid  = bus1.in_valid;
    assign bus0.a         = bus1.a;
    assign bus0.b         = bus1.b;
    assign bus0.sub       = bus1.sub;
    assign bus0.out_ready = bus1.out_ready;

    sm_addsub_pipe #(.N(32), .W(16), .SAT(1'b1)) dut1 (
        .clk_i       (clk),
        .rst_i       (rst),
        .clr_sticky_i(clr),
        .sticky_ovf_o(sticky1),
        .bus         (bus1)
    );

    sm_addsub_pipe #(.N(32), .W(16), .SAT(1'b0)) dut0 (
        .clk_i       (clk),
        .rst_i       (rst),
        .clr_sticky_i(clr),
        .sticky_ovf_o(sticky0),
        .bus         (bus0)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] flags1();
        return {bus1.cout, bus1.zero, bus1.overflow, bus1.neg};
    endfunction

    function automatic logic [3:0] flags0();
        return {bus0.cout, bus0.zero, bus0.overflow, bus0.neg};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op into an empty pipe; result due two edges later.
    task automatic op(input string tag, input logic [31:0] a,
                      input logic [31:0] b, input sm_op_e o,
                      input logic [31:0] ec1, input logic [3:0] ef1,
                      input logic [31:0] ec0, input logic [3:0] ef0);
        bus1.a        = a;
        bus1.b        = b;
        bus1.sub      = (o == SM_SUB);
        bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        chk({tag, "_lat"}, 64'(bus1.out_valid), 64'd0);
        tick();
        chk({tag, "_vld"}, 64'(bus1.out_valid), 64'd1);
        chk({tag, "_c1"}, 64'(bus1.c), 64'(ec1));
        chk({tag, "_f1"}, 64'(flags1()), 64'(ef1));
        chk({tag, "_c0"}, 64'(bus0.c), 64'(ec0));
        chk({tag, "_f0"}, 64'(flags0()), 64'(ef0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        clr            = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.a         = '0;
        bus1.b         = '0;
        bus1.sub       = 1'b0;
        bus1.out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_vld", 64'(bus1.out_valid), 64'd0);
        chk("rst_c", 64'(bus1.c), 64'd0);
        chk("rst_f", 64'(flags1()), 64'd0);
        chk("rst_sticky", 64'(sticky1), 64'd0);
        chk("rst_rdy", 64'(bus1.in_ready), 64'd1);
        rst = 1'b0;
        tick();

        op("p5_n3", 32'h0005, 32'h8003, SM_ADD,
           32'h0002, 4'b0000, 32'h0002, 4'b0000);
        op("p3_n5", 32'h0003, 32'h8005, SM_ADD,
           32'h8002, 4'b0001, 32'h8002, 4'b0001);
        op("p5_s3", 32'h0005, 32'h0003, SM_SUB,
           32'h0002, 4'b0000, 32'h0002, 4'b0000);
        op("n4_p4", 32'h8004, 32'h0004, SM_ADD,
           32'h0000, 4'b0100, 32'h0000, 4'b0100);
        op("upper", 32'hABCD0001, 32'h12340002, SM_ADD,
           32'h0003, 4'b0000, 32'h0003, 4'b0000);
        op("nz_nz", 32'h8000, 32'h8000, SM_ADD,
           32'h0000, 4'b0100, 32'h0000, 4'b0100);
        op("x_x", 32'h8007, 32'h8007, SM_SUB,
           32'h0000, 4'b0100, 32'h0000, 4'b0100);
        op("n3_s5", 32'h8003, 32'h0005, SM_SUB,
           32'h8008, 4'b0001, 32'h8008, 4'b0001);

        op("ovf_pos", 32'h7FFF, 32'h0001, SM_ADD,
           32'h7FFF, 4'b1010, 32'h0000, 4'b1110);
        chk("sticky_pre", 64'(sticky1), 64'd0);
        tick();
        chk("sticky_set", 64'(sticky1), 64'd1);
        op("ovf_neg", 32'hFFFF, 32'h8001, SM_ADD,
           32'hFFFF, 4'b1011, 32'h0000, 4'b1110);
        tick();

        // Two ops in flight, then reset under backpressure.
        bus1.out_ready = 1'b0;
        bus1.a         = 32'h7FFF;
        bus1.b         = 32'h0001;
        bus1.sub       = 1'b0;
        bus1.in_valid  = 1'b1;
        tick();
        bus1.a = 32'h0001;
        tick();
        bus1.in_valid = 1'b0;
        chk("rstm_busy", 64'(bus1.out_valid), 64'd1);
        rst = 1'b1;
        tick();
        chk("rstm_vld", 64'(bus1.out_valid), 64'd0);
        chk("rstm_sticky", 64'(sticky1), 64'd0);
        rst            = 1'b0;
        bus1.out_ready = 1'b1;
        tick();
        chk("rstm_flush", 64'(bus1.out_valid), 64'd0);
        op("rst_after", 32'h0005, 32'h0003, SM_ADD,
           32'h0008, 4'b0000, 32'h0008, 4'b0000);

        op("sticky_op", 32'h7FFF, 32'h0001, SM_ADD,
           32'h7FFF, 4'b1010, 32'h0000, 4'b1110);
        clr = 1'b1;
        tick();
        chk("sticky_win", 64'(sticky1), 64'd1);
        tick();
        chk("sticky_clr", 64'(sticky1), 64'd0);
        clr = 1'b0;

        // Backpressure stream.
        begin
            int   got;
            logic full_seen;
            logic held_v;
            logic [31:0] held;
            got       = 0;
            full_seen = 1'b0;
            held_v    = 1'b0;
            held      = '0;
            fork
                begin
                    logic rdy;
                    for (int i = 0; i < 8; i++) begin
                        bus1.a        = 32'(i + 1);
                        bus1.b        = (i % 2 == 1) ? 32'h8100 : 32'h0100;
                        bus1.sub      = (i % 2 == 1);
                        bus1.in_valid = 1'b1;
                        rdy           = 1'b0;
                        for (int t = 0; t < 40 && !rdy; t++) begin
                            @(negedge clk);
                            rdy = bus1.in_ready;
                            tick();
                        end
                    end
                    bus1.in_valid = 1'b0;
                end
                begin
                    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
                        @(negedge clk);
                        if (bus1.out_valid && !bus1.in_ready)
                            full_seen = 1'b1;
                        if (bus1.out_valid && !bus1.out_ready) begin
                            if (held_v)
                                chk("bp_hold", 64'(bus1.c), 64'(held));
                            held   = bus1.c;
                            held_v = 1'b1;
                        end else begin
                            held_v = 1'b0;
                        end
                        if (bus1.out_valid && bus1.out_ready) begin
                            chk($sformatf("bp_c%0d", got), 64'(bus1.c),
                                64'(32'h0101 + got));
                            got++;
                        end
                        tick();
                        bus1.out_ready = !(cyc >= 3 && cyc < 8);
                    end
                end
            join
            chk("bp_cnt", 64'(got), 64'd8);
            chk("bp_full", 64'(full_seen), 64'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
